// File: rtl/bomb_controller.sv
// Single-bomb lifecycle: place, fuse, blast-cross scan, clear, flame; sole writer of map_mem.
// Optional BOMB_SCORE_EN adds a saturating blocks_destroyed counter output.
module bomb_controller #(
    parameter int NUM_ROW     = 11,
    parameter int NUM_COL     = 19,
    parameter int TILE_SHIFT  = 6,
    parameter int FOOT_OFF_X  = 16,
    parameter int FOOT_OFF_Y  = 48,
    parameter int FUSE_TICKS  = 120,
    parameter int FLAME_TICKS = 30,
    parameter int RANGE       = 2,
    localparam int AW         = $clog2(NUM_ROW * NUM_COL),
    localparam int LW         = $clog2(RANGE + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick,
    input  logic            place_bomb,
    input  logic [10:0]     player_x,
    input  logic [9:0]      player_y,
    output logic [AW-1:0]   map_rd_addr,
    input  logic [1:0]      map_rd_data,
    output logic            map_we,
    output logic [AW-1:0]   map_wr_addr,
    output logic [1:0]      map_wr_data,
    output logic            bomb_active,
    output logic            flame_active,
    output logic [3:0]      bomb_row,
    output logic [4:0]      bomb_col,
    output logic [4*LW-1:0] flame_len
`ifdef BOMB_SCORE_EN
    ,
    output logic [7:0]      blocks_destroyed
`endif
);

    localparam int CMAX = (FUSE_TICKS > FLAME_TICKS) ? FUSE_TICKS : FLAME_TICKS;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [1:0] TILE_FREE = 2'd0;
    localparam logic [1:0] TILE_WALL = 2'd1;
    localparam logic [1:0] TILE_DEST = 2'd2;
    localparam logic [1:0] TILE_BOMB = 2'd3;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_P_RD,
        S_P_CHK,
        S_ARMED,
        S_SCAN_RD,
        S_SCAN_CHK,
        S_CLEAR,
        S_FLAME
    } state_t;

    state_t        state_reg, state_next;
    logic          place_prev_reg;
    logic [3:0]    bomb_row_reg, bomb_row_next;
    logic [4:0]    bomb_col_reg, bomb_col_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [1:0]    dir_reg, dir_next;
    logic [LW-1:0] k_reg, k_next;
    logic [LW-1:0] len_reg [4];
    logic [LW-1:0] len_next [4];
`ifdef BOMB_SCORE_EN
    logic [7:0]    score_reg, score_next;
`endif

    logic          place_edge;
    logic [11:0]   sum_x, sum_y, foot_col, foot_row;
    logic          foot_in_map;
    logic [AW-1:0] bomb_addr, tgt_addr;
    logic [11:0]   row_w, col_w, k_w, tgt_row, tgt_col;
    logic          tgt_off;
    logic          end_dir;

    function automatic logic [AW-1:0] addr_of(input logic [11:0] r, input logic [11:0] c);
        return AW'(32'(r) * NUM_COL + 32'(c));
    endfunction

    // Foot point sampled at 12 bits so the sum cannot wrap before the off-map test.
    always_comb begin
        sum_x       = 12'(player_x) + 12'(FOOT_OFF_X);
        sum_y       = 12'(player_y) + 12'(FOOT_OFF_Y);
        foot_col    = sum_x >> TILE_SHIFT;
        foot_row    = sum_y >> TILE_SHIFT;
        foot_in_map = (foot_row < 12'(NUM_ROW)) && (foot_col < 12'(NUM_COL));
    end

    assign place_edge = place_bomb & ~place_prev_reg;

    // Blast target; underflow is tested before subtracting so the compare stays unsigned.
    always_comb begin
        row_w   = 12'(bomb_row_reg);
        col_w   = 12'(bomb_col_reg);
        k_w     = 12'(k_reg);
        tgt_row = row_w;
        tgt_col = col_w;
        tgt_off = 1'b0;
        case (dir_reg)
            DIR_UP: begin
                if (k_w > row_w) tgt_off = 1'b1;
                else             tgt_row = row_w - k_w;
            end
            DIR_DOWN: begin
                tgt_row = row_w + k_w;
                if (tgt_row >= 12'(NUM_ROW)) tgt_off = 1'b1;
            end
            DIR_LEFT: begin
                if (k_w > col_w) tgt_off = 1'b1;
                else             tgt_col = col_w - k_w;
            end
            default: begin
                tgt_col = col_w + k_w;
                if (tgt_col >= 12'(NUM_COL)) tgt_off = 1'b1;
            end
        endcase
        bomb_addr = addr_of(row_w, col_w);
        tgt_addr  = addr_of(tgt_row, tgt_col);
    end

    always_comb begin
        state_next    = state_reg;
        bomb_row_next = bomb_row_reg;
        bomb_col_next = bomb_col_reg;
        cnt_next      = cnt_reg;
        dir_next      = dir_reg;
        k_next        = k_reg;
        for (int i = 0; i < 4; i++) len_next[i] = len_reg[i];
`ifdef BOMB_SCORE_EN
        score_next    = score_reg;
`endif
        end_dir       = 1'b0;
        map_rd_addr   = '0;
        map_we        = 1'b0;
        map_wr_addr   = '0;
        map_wr_data   = TILE_FREE;
        bomb_active   = 1'b0;
        flame_active  = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (place_edge && foot_in_map) begin
                    bomb_row_next = foot_row[3:0];
                    bomb_col_next = foot_col[4:0];
                    state_next    = S_P_RD;
                end
            end
            S_P_RD: begin
                map_rd_addr = bomb_addr;
                state_next  = S_P_CHK;
            end
            S_P_CHK: begin
                if (map_rd_data == TILE_FREE) begin
                    map_we      = 1'b1;
                    map_wr_addr = bomb_addr;
                    map_wr_data = TILE_BOMB;
                    cnt_next    = '0;
                    state_next  = S_ARMED;
                end else begin
                    state_next  = S_IDLE;
                end
            end
            S_ARMED: begin
                bomb_active = 1'b1;
                if (tick) begin
                    if (cnt_reg == CW'(FUSE_TICKS - 1)) begin
                        dir_next   = DIR_UP;
                        k_next     = LW'(1);
                        for (int i = 0; i < 4; i++) len_next[i] = '0;
                        state_next = S_SCAN_RD;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
            end
            S_SCAN_RD: begin
                bomb_active = 1'b1;
                if (tgt_off) begin
                    end_dir = 1'b1;
                end else begin
                    map_rd_addr = tgt_addr;
                    state_next  = S_SCAN_CHK;
                end
            end
            S_SCAN_CHK: begin
                bomb_active = 1'b1;
                case (map_rd_data)
                    TILE_WALL: end_dir = 1'b1;
                    TILE_DEST: begin
                        map_we            = 1'b1;
                        map_wr_addr       = tgt_addr;
                        map_wr_data       = TILE_FREE;
                        len_next[dir_reg] = len_reg[dir_reg] + LW'(1);
                        end_dir           = 1'b1;
`ifdef BOMB_SCORE_EN
                        if (score_reg != 8'hFF) score_next = score_reg + 8'd1;
`endif
                    end
                    default: begin
                        len_next[dir_reg] = len_reg[dir_reg] + LW'(1);
                        if (k_reg == LW'(RANGE)) begin
                            end_dir = 1'b1;
                        end else begin
                            k_next     = k_reg + LW'(1);
                            state_next = S_SCAN_RD;
                        end
                    end
                endcase
            end
            S_CLEAR: begin
                map_we      = 1'b1;
                map_wr_addr = bomb_addr;
                map_wr_data = TILE_FREE;
                cnt_next    = '0;
                state_next  = S_FLAME;
            end
            S_FLAME: begin
                flame_active = 1'b1;
                if (tick) begin
                    if (cnt_reg == CW'(FLAME_TICKS - 1)) begin
                        for (int i = 0; i < 4; i++) len_next[i] = '0;
                        state_next = S_IDLE;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase

        // Finishing a direction either advances up->down->left->right or leaves the scan.
        if (end_dir) begin
            if (dir_reg == DIR_RIGHT) begin
                state_next = S_CLEAR;
            end else begin
                dir_next   = dir_reg + 2'd1;
                k_next     = LW'(1);
                state_next = S_SCAN_RD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            place_prev_reg <= 1'b0;
            bomb_row_reg   <= '0;
            bomb_col_reg   <= '0;
            cnt_reg        <= '0;
            dir_reg        <= DIR_UP;
            k_reg          <= '0;
        end else begin
            state_reg      <= state_next;
            place_prev_reg <= place_bomb;
            bomb_row_reg   <= bomb_row_next;
            bomb_col_reg   <= bomb_col_next;
            cnt_reg        <= cnt_next;
            dir_reg        <= dir_next;
            k_reg          <= k_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_len
            always_ff @(posedge clk) begin
                if (rst) len_reg[gi] <= '0;
                else     len_reg[gi] <= len_next[gi];
            end
            // Up occupies the most significant field.
            assign flame_len[(3-gi)*LW +: LW] = len_reg[gi];
        end
    endgenerate

`ifdef BOMB_SCORE_EN
    always_ff @(posedge clk) begin
        if (rst) score_reg <= '0;
        else     score_reg <= score_next;
    end
    assign blocks_destroyed = score_reg;
`endif

    assign bomb_row = bomb_row_reg;
    assign bomb_col = bomb_col_reg;

endmodule
